stage_dispatch: RTL and testbench
=================================

STAGE_DISPATCH -- requirements
Module: stage_dispatch

Interface
REQ-001 SHALL have parameter RSA_DW, default 32: data word width for vlr and rk.
REQ-002 SHALL have parameter RSA_AW, default 17: angle word width for alpha and phi.
REQ-003 SHALL have parameter ROW_LEN, default 10: landmark index width.
REQ-004 SHALL have parameter LM_MAX, default 1023: landmark count ceiling.
REQ-005 SHALL have parameter TO_CYC, default 4095: WAIT timeout in cycles, used only when the macro in REQ-030 is defined.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock; sys_rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports cmd_valid  in  1  command offered; cmd_ready  out  1  FIFO not full.
REQ-008 SHALL have ports cmd_stage  in  3  stage code; cmd_lk  in  ROW_LEN  landmark index; cmd_vlr  in  RSA_DW; cmd_alpha  in  RSA_AW; cmd_rk  in  RSA_DW; cmd_phi  in  RSA_AW.
REQ-009 SHALL have ports stage_val  out  3  stage request to the SLAM core; stage_rdy  in  3  completion code from the core.
REQ-010 SHALL have ports l_k  out  ROW_LEN; vlr  out  RSA_DW; alpha  out  RSA_AW; rk  out  RSA_DW; phi  out  RSA_AW; landmark_num  out  ROW_LEN.
REQ-011 SHALL have ports busy  out  1; done_pulse  out  1; done_stage  out  3; err_illegal  out  1; err_timeout  out  1.

Function
REQ-012 SHALL use stage codes IDLE=0, PRD=1, NEW=2, UPD=3, ASSOC=4; codes 5-7 are illegal.
REQ-013 SHALL buffer commands in a 4-entry FIFO holding stage code and all operands; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-014 SHALL drive cmd_ready = 0 when the FIFO holds 4 entries, independent of a same-cycle pop.
REQ-015 SHALL implement states S_IDLE, S_LOAD, S_ISSUE, S_WAIT.
REQ-016 In S_IDLE with the FIFO non-empty, SHALL pop one entry and go to S_LOAD.
REQ-017 In S_LOAD, SHALL register the operands onto l_k/vlr/alpha/rk/phi and hold them until the next S_LOAD.
REQ-018 In S_LOAD, SHALL pulse err_illegal for 1 cycle and return to S_IDLE without issuing when the code is 0 or 5-7, or is NEW while landmark_num == LM_MAX.
REQ-019 SHALL hold stage_val = the stage code for exactly 2 cycles in S_ISSUE; otherwise stage_val = 0.
REQ-020 Latency: for an empty FIFO and S_IDLE, stage_val SHALL first be nonzero in the 3rd cycle after the accepting edge.
REQ-021 In S_WAIT, stage_rdy == issued code SHALL cause a 1-cycle done_pulse with done_stage = that code, then S_IDLE; other stage_rdy values SHALL be ignored.
REQ-022 SHALL increment landmark_num by 1 on NEW completion, saturating at LM_MAX.
REQ-023 busy SHALL be 1 in every state except S_IDLE.
REQ-024 A command accepted while busy SHALL be queued; order SHALL be strictly FIFO.

Reset
REQ-025 On sys_rst SHALL set the state to S_IDLE, empty the FIFO, and clear the timeout counter.
REQ-026 On sys_rst SHALL set all outputs to 0 except cmd_ready, which SHALL be 1.
REQ-027 Reset asserted mid-ISSUE or mid-WAIT SHALL take effect at the next edge; queued commands SHALL be lost.
REQ-028 SHALL deassert reset with landmark_num = 0.

Configuration
REQ-029 SHALL count cycles spent in S_WAIT when the macro STAGE_TIMEOUT_EN is defined.
REQ-030 With STAGE_TIMEOUT_EN defined, reaching TO_CYC cycles in S_WAIT without a match SHALL pulse err_timeout for 1 cycle, produce no done_pulse, leave landmark_num unchanged, and return to S_IDLE.
REQ-031 Without STAGE_TIMEOUT_EN, SHALL wait indefinitely in S_WAIT, tie err_timeout to 0, and instantiate no counter.

Verification
REQ-032 Push ASSOC (lk=2, vlr=2<<19, rk=4<<19) at edge N -> stage_val=4 in cycles N+3 and N+4; l_k=2; stage_rdy=4 -> done_pulse, done_stage=4.
REQ-033 Push 5 commands back-to-back while the core is stalled -> cmd_ready=0 after 4 accepted; the commands are issued in order PRD,NEW,UPD,ASSOC.
REQ-034 Push code 6, then a NEW with landmark_num=LM_MAX -> err_illegal pulses twice, stage_val stays 0, landmark_num unchanged.
REQ-035 NEW completed 3 times from reset -> landmark_num=3.
REQ-036 With STAGE_TIMEOUT_EN and TO_CYC=16, issue UPD and never match -> err_timeout pulses 16 cycles after S_WAIT entry, busy=0; without the macro, busy stays 1.
REQ-037 Assert sys_rst during S_WAIT with 2 queued commands -> next cycle busy=0, stage_val=0, cmd_ready=1, no further issue.

Source files
------------

// File: rtl/stage_dispatch_if.sv
// Command bus into the stage dispatcher: one command word of stage code and operands.
// Latency: none (wires only).
// Backpressure: producer holds cmd_valid and its fields until it sees cmd_ready on an edge.
interface stage_dispatch_if #(
  parameter int RSA_DW  = 32,
  parameter int RSA_AW  = 17,
  parameter int ROW_LEN = 10
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_stage;
  logic [ROW_LEN-1:0] cmd_lk;
  logic [RSA_DW-1:0]  cmd_vlr;
  logic [RSA_AW-1:0]  cmd_alpha;
  logic [RSA_DW-1:0]  cmd_rk;
  logic [RSA_AW-1:0]  cmd_phi;

  modport master (
    output cmd_valid, cmd_stage, cmd_lk, cmd_vlr, cmd_alpha, cmd_rk, cmd_phi,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_stage, cmd_lk, cmd_vlr, cmd_alpha, cmd_rk, cmd_phi,
    output cmd_ready
  );
endinterface

// File: rtl/stage_dispatch.sv
// stage_dispatch: queues SLAM stage commands (4-deep FIFO) and issues them one at a time to the core.
// Latency: stage_val first nonzero in the 3rd cycle after acceptance (empty FIFO, idle), held 2 cycles.
// Backpressure: cmd_ready low while 4 entries are queued; WAIT timeout built only with STAGE_TIMEOUT_EN.

// Small generic FIFO; write and read are ignored when full / empty respectively.
module stage_dispatch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         sys_rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          wr_en;
  logic          rd_en;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign wr_en   = push & ~full;
  assign rd_en   = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Pointer/occupancy update; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module stage_dispatch #(
  parameter int RSA_DW  = 32,
  parameter int RSA_AW  = 17,
  parameter int ROW_LEN = 10,
  parameter int LM_MAX  = 1023,
  parameter int TO_CYC  = 4095
) (
  input  logic               clk,
  input  logic               sys_rst,
  stage_dispatch_if.slave    cmd,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] l_k,
  output logic [RSA_DW-1:0]  vlr,
  output logic [RSA_AW-1:0]  alpha,
  output logic [RSA_DW-1:0]  rk,
  output logic [RSA_AW-1:0]  phi,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic               busy,
  output logic               done_pulse,
  output logic [2:0]         done_stage,
  output logic               err_illegal,
  output logic               err_timeout
);
  localparam logic [2:0]         CODE_NEW   = 3'd2;
  localparam logic [2:0]         CODE_ASSOC = 3'd4;
  localparam logic [ROW_LEN-1:0] LM_CEIL    = ROW_LEN'(LM_MAX);

  typedef struct packed {
    logic [2:0]         stage;
    logic [ROW_LEN-1:0] lk;
    logic [RSA_DW-1:0]  vlr;
    logic [RSA_AW-1:0]  alpha;
    logic [RSA_DW-1:0]  rk;
    logic [RSA_AW-1:0]  phi;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} state_t;

  state_t state;
  state_t state_nxt;
  cmd_t   push_dat;
  cmd_t   head;
  cmd_t   pend;
  logic   push;
  logic   full;
  logic   empty;
  logic   pop;
  logic   load;
  logic   illegal;
  logic   match;
  logic   issue_cnt;
  logic   bad_cmd;

  assign push_dat.stage = cmd.cmd_stage;
  assign push_dat.lk    = cmd.cmd_lk;
  assign push_dat.vlr   = cmd.cmd_vlr;
  assign push_dat.alpha = cmd.cmd_alpha;
  assign push_dat.rk    = cmd.cmd_rk;
  assign push_dat.phi   = cmd.cmd_phi;

  // Ready depends only on occupancy, so a same-cycle pop never opens a slot early.
  assign cmd.cmd_ready = ~full;
  assign push          = cmd.cmd_valid & ~full;

  stage_dispatch_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (4)
  ) u_fifo (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  // Code 0 and 5-7 never reach the core; neither does NEW once the landmark table is full.
  assign bad_cmd = (pend.stage == 3'd0) || (pend.stage > CODE_ASSOC) ||
                   ((pend.stage == CODE_NEW) && (landmark_num == LM_CEIL));

  assign busy      = (state != S_IDLE);
  assign stage_val = (state == S_ISSUE) ? pend.stage : 3'd0;

`ifdef STAGE_TIMEOUT_EN
  localparam int            TOW       = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TOW-1:0] WAIT_LAST = TOW'(TO_CYC - 1);
  logic [TOW-1:0] wait_cnt;
  logic           to_hit;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    illegal   = 1'b0;
    match     = 1'b0;
`ifdef STAGE_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load = 1'b1;
        if (bad_cmd) begin
          illegal   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_cnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stage_rdy == pend.stage) begin
          match     = 1'b1;
          state_nxt = S_IDLE;
        end
`ifdef STAGE_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          to_hit    = 1'b1;
          state_nxt = S_IDLE;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command capture, operand outputs, completion reporting and landmark count.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pend         <= '0;
      l_k          <= '0;
      vlr          <= '0;
      alpha        <= '0;
      rk           <= '0;
      phi          <= '0;
      landmark_num <= '0;
      done_pulse   <= 1'b0;
      done_stage   <= 3'd0;
      err_illegal  <= 1'b0;
      issue_cnt    <= 1'b0;
    end else begin
      done_pulse  <= match;
      err_illegal <= illegal;
      issue_cnt   <= (state == S_ISSUE) && !issue_cnt;
      if (pop) begin
        pend <= head;
      end
      if (load) begin
        l_k   <= pend.lk;
        vlr   <= pend.vlr;
        alpha <= pend.alpha;
        rk    <= pend.rk;
        phi   <= pend.phi;
      end
      if (match) begin
        done_stage <= pend.stage;
        if ((pend.stage == CODE_NEW) && (landmark_num != LM_CEIL)) begin
          landmark_num <= landmark_num + 1'b1;
        end
      end
    end
  end

`ifdef STAGE_TIMEOUT_EN
  // WAIT cycle counter; restarts on every WAIT entry and gives up after TO_CYC cycles.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= to_hit;
      wait_cnt    <= ((state == S_WAIT) && !match && !to_hit) ? wait_cnt + 1'b1 : '0;
    end
  end
`else
  // Without the timeout, WAIT is left only by a matching completion code.
  assign err_timeout = 1'b0;
  // TO_CYC only sizes the counter in the timeout build; this empty block keeps it referenced.
  if (TO_CYC < 1) begin : g_to_cyc_ref
  end
`endif
endmodule

// File: tb/tb_stage_dispatch.sv
// Self-checking bench for stage_dispatch: vector table, corner sequences, randomized run vs queue model.
// Latency: checks stage_val timing relative to the accepting edge.
// Backpressure: exercises FIFO full / cmd_ready and a stalled core.
module tb_stage_dispatch;
  localparam int DW   = 32;
  localparam int AW   = 17;
  localparam int RL   = 10;
  localparam int LMX  = 5;
  localparam int TOC  = 16;
  localparam int NCMD = 120;

  typedef struct {
    logic [2:0]    stage;
    logic [RL-1:0] lk;
    logic [DW-1:0] vlr;
    logic [AW-1:0] alpha;
    logic [DW-1:0] rk;
    logic [AW-1:0] phi;
  } cmd_t;

  typedef struct {
    cmd_t c;
    bit   legal;
    int   lm_after;
  } vec_t;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [2:0]    stage_val;
  logic [2:0]    stage_rdy = 3'd0;
  logic [2:0]    done_stage;
  logic [RL-1:0] l_k;
  logic [RL-1:0] landmark_num;
  logic [DW-1:0] vlr;
  logic [DW-1:0] rk;
  logic [AW-1:0] alpha;
  logic [AW-1:0] phi;
  logic busy, done_pulse, err_illegal, err_timeout;

  int checks = 0;
  int failures = 0;
  logic [2:0] issued[$];
  cmd_t mq[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  stage_dispatch_if #(.RSA_DW(DW), .RSA_AW(AW), .ROW_LEN(RL)) cmd_bus ();

  stage_dispatch #(
    .RSA_DW(DW), .RSA_AW(AW), .ROW_LEN(RL), .LM_MAX(LMX), .TO_CYC(TOC)
  ) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .cmd          (cmd_bus),
    .stage_val    (stage_val),
    .stage_rdy    (stage_rdy),
    .l_k          (l_k),
    .vlr          (vlr),
    .alpha        (alpha),
    .rk           (rk),
    .phi          (phi),
    .landmark_num (landmark_num),
    .busy         (busy),
    .done_pulse   (done_pulse),
    .done_stage   (done_stage),
    .err_illegal  (err_illegal),
    .err_timeout  (err_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cmd_t c);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_stage = c.stage;
    cmd_bus.cmd_lk    = c.lk;
    cmd_bus.cmd_vlr   = c.vlr;
    cmd_bus.cmd_alpha = c.alpha;
    cmd_bus.cmd_rk    = c.rk;
    cmd_bus.cmd_phi   = c.phi;
  endtask

  function automatic cmd_t mk(input logic [2:0] st, input logic [RL-1:0] lk,
                              input logic [DW-1:0] v, input logic [DW-1:0] r);
    cmd_t c;
    c.stage = st;
    c.lk    = lk;
    c.vlr   = v;
    c.alpha = AW'(lk) + 17'h100;
    c.rk    = r;
    c.phi   = AW'(lk) ^ 17'h1ABCD;
    return c;
  endfunction

  task automatic do_reset();
    sys_rst = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    stage_rdy = 3'd0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  // Push one command and leave the DUT in WAIT (stage_val has finished its 2 cycles).
  task automatic push_to_wait(input cmd_t c);
    drive(c);
    tick();
    cmd_bus.cmd_valid = 1'b0;
    repeat (4) tick();
  endtask

  // Services issues in order, answering each with its own code, and logs the issued codes.
  task automatic serve(input int cycles);
    logic [2:0] prev = 3'd0;
    logic [2:0] code = 3'd0;
    bit waiting = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      stage_rdy = 3'd0;
      if (stage_val != 3'd0 && prev == 3'd0) begin
        issued.push_back(stage_val);
        code = stage_val;
        waiting = 1'b1;
      end else if (waiting && stage_val == 3'd0) begin
        stage_rdy = code;
        waiting = 1'b0;
      end
      prev = stage_val;
      tick();
    end
    stage_rdy = 3'd0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    drive(v.c);
    tick();                                   // accepting edge N
    cmd_bus.cmd_valid = 1'b0;
    check({t, "_n0_stage_val"}, stage_val, 0);
    check({t, "_n0_busy"}, busy, 0);
    tick();                                   // N+1: LOAD
    check({t, "_n1_stage_val"}, stage_val, 0);
    check({t, "_n1_busy"}, busy, 1);
    tick();                                   // N+2
    if (v.legal) begin
      check({t, "_n2_stage_val"}, stage_val, v.c.stage);
      check({t, "_l_k"}, l_k, v.c.lk);
      check({t, "_vlr"}, vlr, v.c.vlr);
      check({t, "_alpha"}, alpha, v.c.alpha);
      check({t, "_rk"}, rk, v.c.rk);
      check({t, "_phi"}, phi, v.c.phi);
      tick();
      check({t, "_n3_stage_val"}, stage_val, v.c.stage);
      tick();
      check({t, "_n4_stage_val"}, stage_val, 0);
      check({t, "_n4_busy"}, busy, 1);
      stage_rdy = v.c.stage ^ 3'd1;           // wrong code must be ignored
      repeat (2) begin
        tick();
        check({t, "_wrong_rdy_no_done"}, done_pulse, 0);
      end
      stage_rdy = v.c.stage;
      tick();
      stage_rdy = 3'd0;
      check({t, "_done_pulse"}, done_pulse, 1);
      check({t, "_done_stage"}, done_stage, v.c.stage);
      check({t, "_landmark"}, landmark_num, v.lm_after);
      tick();
      check({t, "_done_one_cycle"}, done_pulse, 0);
      check({t, "_idle_busy"}, busy, 0);
    end else begin
      check({t, "_err_illegal"}, err_illegal, 1);
      check({t, "_illegal_stage_val"}, stage_val, 0);
      check({t, "_illegal_busy"}, busy, 0);
      tick();
      check({t, "_err_illegal_1cyc"}, err_illegal, 0);
      check({t, "_illegal_stage_val2"}, stage_val, 0);
      check({t, "_landmark"}, landmark_num, v.lm_after);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit ready_before;
    bit seen;
    bit all_busy;
    int first;
    logic [2:0] exp_order[4];
    logic [2:0] order_codes[5];
    cmd_t h;
    cmd_t cur;
    cmd_t rc;
    int lm_model;
    int pushed;
    int run_len;
    int delay;
    bit waiting;
    bit exp_legal;
    bit drained;
    logic [2:0] prev_sv;
    logic [2:0] r;

    vecs[0]  = '{mk(3'd4, 10'd2,  32'd2 << 19, 32'd4 << 19), 1'b1, 0};
    vecs[1]  = '{mk(3'd2, 10'd7,  32'h1234,    32'h5678),    1'b1, 1};
    vecs[2]  = '{mk(3'd2, 10'd8,  32'hFFFF_FFFF, 32'h0),     1'b1, 2};
    vecs[3]  = '{mk(3'd2, 10'd9,  32'h0,       32'hFFFF_FFFF), 1'b1, 3};
    vecs[4]  = '{mk(3'd6, 10'd1,  32'h11,      32'h22),      1'b0, 3};
    vecs[5]  = '{mk(3'd0, 10'd3,  32'h33,      32'h44),      1'b0, 3};
    vecs[6]  = '{mk(3'd1, 10'h3FF, 32'hA5A5_A5A5, 32'h5A5A_5A5A), 1'b1, 3};
    vecs[7]  = '{mk(3'd3, 10'd0,  32'h8000_0000, 32'h1),     1'b1, 3};
    vecs[8]  = '{mk(3'd2, 10'd4,  32'h77,      32'h88),      1'b1, 4};
    vecs[9]  = '{mk(3'd2, 10'd5,  32'h99,      32'hAA),      1'b1, 5};
    vecs[10] = '{mk(3'd2, 10'd6,  32'hBB,      32'hCC),      1'b0, 5};
    vecs[11] = '{mk(3'd7, 10'd6,  32'hDD,      32'hEE),      1'b0, 5};
    order_codes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    exp_order   = '{3'd1, 3'd2, 3'd3, 3'd4};

    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_stage = 3'd0;
    cmd_bus.cmd_lk    = '0;
    cmd_bus.cmd_vlr   = '0;
    cmd_bus.cmd_alpha = '0;
    cmd_bus.cmd_rk    = '0;
    cmd_bus.cmd_phi   = '0;

    // Reset values.
    do_reset();
    check("rst_cmd_ready", cmd_bus.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_stage_val", stage_val, 0);
    check("rst_l_k", l_k, 0);
    check("rst_vlr", vlr, 0);
    check("rst_landmark", landmark_num, 0);
    check("rst_done_pulse", done_pulse, 0);
    check("rst_done_stage", done_stage, 0);
    check("rst_err_illegal", err_illegal, 0);
    check("rst_err_timeout", err_timeout, 0);

    // Single-command vectors, landmark count carried from one to the next.
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Stalled core: 4 queued behind an in-flight command, 5th refused, FIFO order kept.
    do_reset();
    push_to_wait(mk(3'd3, 10'd0, 32'h1, 32'h2));
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(mk(order_codes[i], RL'(i + 10), 32'(i), 32'(i * 2)));
      ready_before = cmd_bus.cmd_ready;
      tick();
      if (ready_before) acc++;
    end
    cmd_bus.cmd_valid = 1'b0;
    check("fill_accepted", acc, 4);
    check("fill_cmd_ready_low", cmd_bus.cmd_ready, 0);
    stage_rdy = 3'd3;
    tick();
    stage_rdy = 3'd0;
    check("fill_blocker_done", done_pulse, 1);
    issued.delete();
    serve(80);
    check("fill_issue_count", issued.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < issued.size()) check($sformatf("fill_order%0d", i), issued[i], exp_order[i]);
    end
    check("fill_landmark", landmark_num, 1);
    check("fill_cmd_ready_back", cmd_bus.cmd_ready, 1);

    // Reset while waiting with 2 commands queued: everything is dropped.
    do_reset();
    push_to_wait(mk(3'd3, 10'd1, 32'h3, 32'h4));
    drive(mk(3'd1, 10'd2, 32'h5, 32'h6));
    tick();
    drive(mk(3'd2, 10'd3, 32'h7, 32'h8));
    tick();
    cmd_bus.cmd_valid = 1'b0;
    check("rstwait_busy_before", busy, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("rstwait_busy", busy, 0);
    check("rstwait_stage_val", stage_val, 0);
    check("rstwait_cmd_ready", cmd_bus.cmd_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stage_rdy = 3'($urandom_range(1, 7));
      tick();
      if (stage_val != 3'd0 || busy) seen = 1'b1;
    end
    stage_rdy = 3'd0;
    check("rstwait_no_issue", seen, 0);

    // WAIT without a matching completion.
    do_reset();
    push_to_wait(mk(3'd3, 10'd4, 32'h9, 32'hA));
`ifdef STAGE_TIMEOUT_EN
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      stage_rdy = 3'd1;
      tick();
      if (err_timeout && first < 0) begin
        first = k;
        check("to_busy_at_timeout", busy, 0);
        check("to_no_done", done_pulse, 0);
      end
    end
    check("to_cycles_after_wait_entry", first, TOC);
    check("to_landmark", landmark_num, 0);
`else
    all_busy = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      stage_rdy = 3'd1;
      tick();
      all_busy &= busy;
      if (err_timeout) seen = 1'b1;
    end
    check("noto_busy_held", all_busy, 1);
    check("noto_err_timeout", seen, 0);
`endif
    stage_rdy = 3'd0;

    // Randomized traffic against an in-order queue model.
    do_reset();
    mq.delete();
    lm_model = 0;
    pushed = 0;
    run_len = 0;
    delay = 0;
    waiting = 1'b0;
    drained = 1'b0;
    prev_sv = 3'd0;
    cur = mk(3'd0, '0, '0, '0);
    for (int c = 0; c < 8000; c++) begin
      if (err_illegal || (stage_val != 3'd0 && prev_sv == 3'd0)) begin
        check("rnd_event_has_cmd", mq.size() != 0, 1);
        if (mq.size() != 0) begin
          h = mq.pop_front();
          exp_legal = !(h.stage == 3'd0 || h.stage > 3'd4 || (h.stage == 3'd2 && lm_model == LMX));
          check("rnd_legality", !err_illegal, exp_legal);
          if (!err_illegal) begin
            check("rnd_stage_val", stage_val, h.stage);
            check("rnd_l_k", l_k, h.lk);
            check("rnd_vlr", vlr, h.vlr);
            check("rnd_alpha", alpha, h.alpha);
            check("rnd_rk", rk, h.rk);
            check("rnd_phi", phi, h.phi);
            cur = h;
            waiting = 1'b1;
            delay = $urandom_range(0, 6);
            run_len = 0;
          end
        end
      end
      if (stage_val != 3'd0) run_len++;
      if (stage_val == 3'd0 && prev_sv != 3'd0) check("rnd_issue_len", run_len, 2);
      if (done_pulse) begin
        check("rnd_done_stage", done_stage, cur.stage);
        if (cur.stage == 3'd2 && lm_model < LMX) lm_model++;
        check("rnd_landmark", landmark_num, lm_model);
      end
      prev_sv = stage_val;
      if (pushed == NCMD && mq.size() == 0 && !waiting && !busy && !cmd_bus.cmd_valid) begin
        drained = 1'b1;
        break;
      end
      r = 3'($urandom_range(0, 7));
      if (waiting && stage_val == 3'd0) begin
        if (delay == 0) begin
          r = cur.stage;
          waiting = 1'b0;
        end else begin
          delay--;
          if (r == cur.stage) r = r ^ 3'd1;
        end
      end
      stage_rdy = r;
      if (pushed < NCMD && $urandom_range(0, 2) != 0) begin
        rc.stage = 3'($urandom_range(0, 7));
        rc.lk    = RL'($urandom);
        rc.vlr   = $urandom;
        rc.alpha = AW'($urandom);
        rc.rk    = $urandom;
        rc.phi   = AW'($urandom);
        drive(rc);
        if (cmd_bus.cmd_ready) begin
          mq.push_back(rc);
          pushed++;
        end
      end else begin
        cmd_bus.cmd_valid = 1'b0;
      end
      tick();
    end
    stage_rdy = 3'd0;
    cmd_bus.cmd_valid = 1'b0;
    check("rnd_drained", drained, 1);
    check("rnd_final_landmark", landmark_num, lm_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
